// File: rtl/ip_stream_format_pipe_out.sv
// IP-stream receive stage: pairs buffered packet lines with their header checksum
// verdict, forwards good packets through a single-slot output register and drops the rest.

package ip_stream_format_pipe_out_pkg;
  localparam int MAC_INTERFACE_W = 512;
  localparam int MAC_PADBYTES_W  = $clog2(MAC_INTERFACE_W / 8);
  localparam int TIMESTAMP_W     = 64;
  localparam int IP_HDR_W        = 160;

  typedef struct packed {
    logic [TIMESTAMP_W-1:0] timestamp;
  } tracker_stats_struct;

  typedef struct packed {
    logic [MAC_INTERFACE_W-1:0] data;
    logic [MAC_PADBYTES_W-1:0]  padbytes;
    logic                       last;
    tracker_stats_struct        timestamp;
  } fifo_struct;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ip_hdr_len;
    logic [7:0]  tos;
    logic [15:0] tot_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] chksum;
    logic [31:0] source_addr;
    logic [31:0] dest_addr;
  } ip_pkt_hdr;
endpackage

module ip_stream_format_pipe_out
  import ip_stream_format_pipe_out_pkg::*;
#(
  parameter int DATA_WIDTH     = MAC_INTERFACE_W,
  parameter int DATA_BYTES     = DATA_WIDTH / 8,
  parameter int PADBYTES_WIDTH = $clog2(DATA_BYTES),
  parameter int CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst,

  output logic                      data_fifo_out_rd_req,
  input  logic                      data_fifo_out_empty,
  input  fifo_struct                data_fifo_out_rd_data,

  input  logic                      ip_chksum_resp_val,
  input  logic [15:0]               ip_chksum_resp_data,
  output logic                      ip_chksum_resp_rdy,

  output logic                      ip_format_dst_rx_val,
  output logic [DATA_WIDTH-1:0]     ip_format_dst_rx_data,
  output logic                      ip_format_dst_rx_last,
  output logic [PADBYTES_WIDTH-1:0] ip_format_dst_rx_padbytes,
  output tracker_stats_struct       ip_format_dst_rx_timestamp,
  input  logic                      dst_ip_format_rx_rdy,

  output logic [CNT_W-1:0]          ip_pkt_accept_cnt,
  output logic [CNT_W-1:0]          ip_pkt_drop_cnt
);

  typedef enum logic [1:0] {
    HDR_WAIT = 2'd0,
    FWD      = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic       out_val_reg;
  fifo_struct out_line_reg;

  logic [CNT_W-1:0] accept_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  ip_pkt_hdr hdr;
  logic      hdr_fields_ok;
  logic      hdr_ok;
  logic      head_last;
  logic      out_free;
  logic      decide;

  logic      rd_req_next;
  logic      resp_rdy_next;
  logic      load_next;
  logic      accept_inc_next;
  logic      drop_inc_next;

  // Only version and IHL are judged here; the rest of the header is the parser's business.
  function automatic logic hdr_is_ipv4(input ip_pkt_hdr h);
    return (h.version == 4'd4) && (h.ip_hdr_len >= 4'd5);
  endfunction

  assign hdr           = ip_pkt_hdr'(data_fifo_out_rd_data.data[DATA_WIDTH-1 -: IP_HDR_W]);
  assign hdr_fields_ok = hdr_is_ipv4(hdr);
  assign hdr_ok        = hdr_fields_ok && (ip_chksum_resp_data == 16'h0000);
  assign head_last     = data_fifo_out_rd_data.last;

  // The slot can take a line if it is empty or is being emptied this cycle.
  assign out_free = ~out_val_reg | dst_ip_format_rx_rdy;

  // A bad header never needs the slot, so drops are decided regardless of backpressure.
  assign decide = ~data_fifo_out_empty & ip_chksum_resp_val & (out_free | ~hdr_ok);

  always_comb begin
    rd_req_next     = 1'b0;
    resp_rdy_next   = 1'b0;
    load_next       = 1'b0;
    accept_inc_next = 1'b0;
    drop_inc_next   = 1'b0;
    state_next      = state_reg;

    case (state_reg)
      HDR_WAIT: begin
        if (decide) begin
          resp_rdy_next = 1'b1;
          rd_req_next   = 1'b1;
          if (hdr_ok) begin
            load_next       = 1'b1;
            accept_inc_next = 1'b1;
            state_next      = head_last ? HDR_WAIT : FWD;
          end else begin
            drop_inc_next = 1'b1;
            state_next    = head_last ? HDR_WAIT : DROP;
          end
        end
      end

      FWD: begin
        if (~data_fifo_out_empty & out_free) begin
          rd_req_next = 1'b1;
          load_next   = 1'b1;
          if (head_last) begin
            state_next = HDR_WAIT;
          end
        end
      end

      DROP: begin
        if (~data_fifo_out_empty) begin
          rd_req_next = 1'b1;
          if (head_last) begin
            state_next = HDR_WAIT;
          end
        end
      end

      default: begin
        rd_req_next     = 1'bx;
        resp_rdy_next   = 1'bx;
        load_next       = 1'bx;
        accept_inc_next = 1'bx;
        drop_inc_next   = 1'bx;
        state_next      = state_t'(2'bxx);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= HDR_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val_reg  <= 1'b0;
      out_line_reg <= '0;
    end else if (load_next) begin
      out_val_reg  <= 1'b1;
      out_line_reg <= data_fifo_out_rd_data;
    end else if (dst_ip_format_rx_rdy) begin
      out_val_reg  <= 1'b0;
    end
  end

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_reg <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      if (accept_inc_next) begin
        accept_cnt_reg <= accept_cnt_reg + 1'b1;
      end
      if (drop_inc_next) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign data_fifo_out_rd_req       = rd_req_next;
  assign ip_chksum_resp_rdy         = resp_rdy_next;

  assign ip_format_dst_rx_val       = out_val_reg;
  assign ip_format_dst_rx_data      = out_line_reg.data;
  assign ip_format_dst_rx_last      = out_line_reg.last;
  assign ip_format_dst_rx_padbytes  = out_line_reg.padbytes;
  assign ip_format_dst_rx_timestamp = out_line_reg.timestamp;

  assign ip_pkt_accept_cnt          = accept_cnt_reg;
  assign ip_pkt_drop_cnt            = drop_cnt_reg;

  a_no_double_count: assert property (@(posedge clk) disable iff (rst)
    !(accept_inc_next && drop_inc_next));

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
    rd_req_next |-> !data_fifo_out_empty);

  a_resp_paired_with_pop: assert property (@(posedge clk) disable iff (rst)
    resp_rdy_next |-> rd_req_next);

endmodule

// File: doc/ip_stream_format_pipe_out.md
Name: ip_stream_format_pipe_out

Overview:
- Receive-path stage directly downstream of the IP-stream input formatter.
- Pops buffered packet lines from the formatter's data FIFO and pairs each packet with its IP header checksum result from the checksum engine.
- Forwards good packets unchanged on a valid/ready stream to the IP header parser.
- Drops packets whose checksum, version or IHL is bad, and counts accepted and dropped packets.

Parameters:
DATA_WIDTH, 512, stream line width in bits (equals MAC_INTERFACE_W).
DATA_BYTES, DATA_WIDTH/8, bytes per line.
PADBYTES_WIDTH, $clog2(DATA_BYTES), width of the padbytes field.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
data_fifo_out_rd_req  out  1  pop the FIFO head (show-ahead FIFO)
data_fifo_out_empty  in  1  FIFO empty
data_fifo_out_rd_data  in  fifo_struct  head line: data, padbytes, last, timestamp
ip_chksum_resp_val  in  1  checksum result valid (one per packet, in packet order)
ip_chksum_resp_data  in  16  folded one's-complement result; 16'h0000 means good
ip_chksum_resp_rdy  out  1  checksum result consumed
ip_format_dst_rx_val  out  1  output line valid
ip_format_dst_rx_data  out  DATA_WIDTH  output line data
ip_format_dst_rx_last  out  1  last line of packet
ip_format_dst_rx_padbytes  out  PADBYTES_WIDTH  pad bytes on last line
ip_format_dst_rx_timestamp  out  tracker_stats_struct  per-line timestamp, passed through
dst_ip_format_rx_rdy  in  1  downstream ready
ip_pkt_accept_cnt  out  CNT_W  packets forwarded
ip_pkt_drop_cnt  out  CNT_W  packets dropped

Behaviour:
- Reset (async): FSM in HDR_WAIT; output register empty, so ip_format_dst_rx_val=0; both counters 0.
- After reset, rd_req=0 and chksum_resp_rdy=0 until the decision condition below is met.
- Output stage: one register slot. out_free = ~ip_format_dst_rx_val | dst_ip_format_rx_rdy. On a pop into the output, the slot loads the line with val=1. If not loaded, val clears when dst_ip_format_rx_rdy=1.
- Latency: FIFO head to output is 1 cycle.
- Output data, last, padbytes and timestamp are held stable while val=1 and rdy=0.
- FIFO head fields: data is data_fifo_out_rd_data.data; hdr = data[DATA_WIDTH-1 -: IP_HDR_W], cast to ip_pkt_hdr.
- hdr_ok = (version==4) & (ip_hdr_len>=5) & (ip_chksum_resp_data==0).

FSM states and transitions:
- HDR_WAIT:
  - Decision condition: ~data_fifo_out_empty & ip_chksum_resp_val & (out_free | ~hdr_ok).
  - When met, assert ip_chksum_resp_rdy=1 and data_fifo_out_rd_req=1 in the same cycle.
  - If hdr_ok: load the output slot, ip_pkt_accept_cnt+1, next state = last ? HDR_WAIT : FWD.
  - Else: nothing goes to the output, ip_pkt_drop_cnt+1, next state = last ? HDR_WAIT : DROP.
- FWD:
  - rd_req = ~empty & out_free; each pop loads the output slot.
  - On a popped line with last=1, go to HDR_WAIT.
- DROP:
  - rd_req = ~empty, regardless of downstream.
  - On a popped line with last=1, go to HDR_WAIT.

Boundary rules:
- A checksum result arriving before FIFO data is held, with resp_rdy=0, until the line appears.
- FIFO data arriving before the result is not popped.
- A single-line packet is decided and finished in one cycle; a back-to-back next packet may be decided in the following cycle.
- Drops never stall on downstream backpressure.
- Counters wrap modulo 2^CNT_W.
- Accept and drop are never incremented in the same cycle.
- Reset mid-packet: FSM, output slot and counters return to reset values immediately. Upstream is reset by the same rst, so the FIFO and checksum pairing restart aligned.
- An illegal FSM state drives outputs to X in simulation.

Test Plan:
- Reset hold: rst=1 -> ip_format_dst_rx_val=0, both counters 0, rd_req=0 and chksum_resp_rdy=0 until a decision.
- Good 3-line packet (version 4, IHL 5, chksum 16'h0000), dst rdy=1 -> 3 output beats on consecutive cycles, 1 cycle after each pop; last=1 on beat 3 with padbytes equal to input; accept_cnt=1.
- Bad checksum 16'h1234 on a 4-line packet, dst rdy=0 throughout -> 4 pops in 4 cycles, val stays 0, drop_cnt=1, FSM back in HDR_WAIT.
- Version 6 header with chksum 0, then a good 1-line packet back-to-back -> first packet dropped and second forwarded; drop_cnt=1, accept_cnt=1; no idle cycle between the decisions.
- Backpressure: good 2-line packet with dst rdy toggling 1,0,0,1 -> data and timestamp held stable while rdy=0; exactly 2 beats delivered; FIFO never popped while the slot is full and not draining.
- Checksum result arrives 5 cycles before FIFO data; then a reset is asserted mid-packet on line 2 -> no pop before the data arrives; after reset val=0, counters 0, and the next packet is processed correctly.
